// File: rtl/multi_byte_alu_sequencer.sv
// multi_byte_alu_sequencer: runs a byte-wide ALU LSB-first over NUM_BYTES
// bytes, chaining carry/borrow, and reports the wide result and flags.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              request, sampled in IDLE only
//   a_i, b_i             wide operands, latched on accepted start
//   f_i                  ALU function code, latched on accepted start
//   carry_borrow_i       carry/borrow into byte 0
//   busy_o, done_o       busy in RUN/DONE, one-cycle done pulse
//   y_o                  wide result, held until next accepted start
//   carry_borrow_o       final carry/borrow (add/sub only)
//   status_flag_o        wide status flag

package multi_byte_alu_pkg;
    localparam int DATA_WIDTH    = 8;
    localparam int CONTROL_WIDTH = 3;

    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_PLUS_B  = 3'd0;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_MINUS_B = 3'd1;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_AND_B   = 3'd2;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_OR_B    = 3'd3;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_XOR_B   = 3'd4;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_NOT_A     = 3'd5;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A         = 3'd6;
    localparam logic [CONTROL_WIDTH-1:0] OUTPUT_B         = 3'd7;

    localparam logic [1:0] DEFAULT_FLAG  = 2'd0;
    localparam logic [1:0] OVERFLOW_FLAG = 2'd1;
    localparam logic [1:0] ZERO_FLAG     = 2'd2;
    localparam logic [1:0] NEGATIVE_FLAG = 2'd3;
endpackage

module eight_bit_alu
    import multi_byte_alu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]    a_i,
    input  logic [DATA_WIDTH-1:0]    b_i,
    input  logic [CONTROL_WIDTH-1:0] f_i,
    input  logic                     carry_borrow_i,
    output logic [DATA_WIDTH-1:0]    y_o,
    output logic                     carry_borrow_o
);
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0] cb;

    always_comb begin
        cb   = {{DATA_WIDTH{1'b0}}, carry_borrow_i};
        // Bit DATA_WIDTH of the 9-bit difference is set when it wraps negative.
        sum  = {1'b0, a_i} + {1'b0, b_i} + cb;
        diff = {1'b0, a_i} - {1'b0, b_i} - cb;
        y_o            = '0;
        carry_borrow_o = 1'b0;
        case (f_i)
            OUTPUT_A_PLUS_B: begin
                y_o            = sum[DATA_WIDTH-1:0];
                carry_borrow_o = sum[DATA_WIDTH];
            end
            OUTPUT_A_MINUS_B: begin
                y_o            = diff[DATA_WIDTH-1:0];
                carry_borrow_o = diff[DATA_WIDTH];
            end
            OUTPUT_A_AND_B: y_o = a_i & b_i;
            OUTPUT_A_OR_B:  y_o = a_i | b_i;
            OUTPUT_A_XOR_B: y_o = a_i ^ b_i;
            OUTPUT_NOT_A:   y_o = ~a_i;
            OUTPUT_A:       y_o = a_i;
            OUTPUT_B:       y_o = b_i;
            default:        y_o = '0;
        endcase
    end
endmodule

module multi_byte_alu_sequencer
    import multi_byte_alu_pkg::*;
#(
    parameter int NUM_BYTES = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0]   a_i,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0]   b_i,
    input  logic [CONTROL_WIDTH-1:0]          f_i,
    input  logic                              carry_borrow_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [NUM_BYTES*DATA_WIDTH-1:0]   y_o,
    output logic                              carry_borrow_o,
    output logic [1:0]                        status_flag_o
);
    localparam int W  = NUM_BYTES * DATA_WIDTH;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_n;
    logic [W-1:0]             a_q, b_q, res_q, res_n;
    logic [CONTROL_WIDTH-1:0] f_q;
    logic                     chain_q;
    logic [IW-1:0]            idx;
    logic [DATA_WIDTH-1:0]    alu_y;
    logic                     alu_c;
    logic [W+DATA_WIDTH-1:0]  shift;
    logic                     arith;
    logic                     c_n;
    logic [1:0]               flag_n;

    // Operands shift right each RUN cycle, so byte 0 always feeds the ALU.
    eight_bit_alu u_alu (
        .a_i            (a_q[DATA_WIDTH-1:0]),
        .b_i            (b_q[DATA_WIDTH-1:0]),
        .f_i            (f_q),
        .carry_borrow_i (chain_q),
        .y_o            (alu_y),
        .carry_borrow_o (alu_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_i) state_n = RUN;
            RUN:     if (idx == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // New byte enters at the top; after NUM_BYTES shifts it is aligned.
        shift = {alu_y, res_q};
        res_n = shift[W+DATA_WIDTH-1:DATA_WIDTH];

        arith = (f_q == OUTPUT_A_PLUS_B) || (f_q == OUTPUT_A_MINUS_B);
        c_n   = arith & alu_c;

        if (f_q == OUTPUT_A_PLUS_B && alu_c)
            flag_n = OVERFLOW_FLAG;
        else if (f_q == OUTPUT_A_MINUS_B && alu_c)
            flag_n = NEGATIVE_FLAG;
        else if (res_n == '0)
            flag_n = ZERO_FLAG;
        else
            flag_n = DEFAULT_FLAG;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q            <= '0;
            b_q            <= '0;
            f_q            <= '0;
            chain_q        <= 1'b0;
            idx            <= '0;
            res_q          <= '0;
            y_o            <= '0;
            carry_borrow_o <= 1'b0;
            status_flag_o  <= DEFAULT_FLAG;
        end else begin
            if (state == IDLE && start_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                f_q     <= f_i;
                chain_q <= carry_borrow_i;
                idx     <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> DATA_WIDTH;
                b_q     <= b_q >> DATA_WIDTH;
                res_q   <= res_n;
                chain_q <= alu_c;
                idx     <= idx + IW'(1);
                if (idx == LAST) begin
                    y_o            <= res_n;
                    carry_borrow_o <= c_n;
                    status_flag_o  <= flag_n;
                end
            end
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);
endmodule

// File: tb/tb_multi_byte_alu_sequencer.sv
// Bench for multi_byte_alu_sequencer: directed and random ops on
// NUM_BYTES = 1, 2 and 4 instances, scoreboard-checked on done.

module tb_multi_byte_alu_sequencer;
    import multi_byte_alu_pkg::*;

    typedef struct packed {
        logic [63:0] y;
        logic        c;
        logic [1:0]  fl;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [2:0]  f = '0;
    logic        cin = 1'b0;

    logic        busy1, done1, c1;
    logic        busy2, done2, c2;
    logic        busy4, done4, c4;
    logic [7:0]  y1;
    logic [15:0] y2;
    logic [31:0] y4;
    logic [1:0]  fl1, fl2, fl4;

    int          sel = 2;
    logic        o_busy, o_done, o_c;
    logic [63:0] o_y;
    logic [1:0]  o_fl;

    int   n_chk = 0;
    int   n_fail = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    multi_byte_alu_sequencer #(.NUM_BYTES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .a_i(a[7:0]), .b_i(b[7:0]), .f_i(f), .carry_borrow_i(cin),
        .busy_o(busy1), .done_o(done1), .y_o(y1),
        .carry_borrow_o(c1), .status_flag_o(fl1)
    );

    multi_byte_alu_sequencer #(.NUM_BYTES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2),
        .a_i(a[15:0]), .b_i(b[15:0]), .f_i(f), .carry_borrow_i(cin),
        .busy_o(busy2), .done_o(done2), .y_o(y2),
        .carry_borrow_o(c2), .status_flag_o(fl2)
    );

    multi_byte_alu_sequencer #(.NUM_BYTES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4),
        .a_i(a[31:0]), .b_i(b[31:0]), .f_i(f), .carry_borrow_i(cin),
        .busy_o(busy4), .done_o(done4), .y_o(y4),
        .carry_borrow_o(c4), .status_flag_o(fl4)
    );

    always_comb begin
        o_busy = busy2; o_done = done2; o_c = c2;
        o_y = {48'b0, y2}; o_fl = fl2;
        case (sel)
            1: begin
                o_busy = busy1; o_done = done1; o_c = c1;
                o_y = {56'b0, y1}; o_fl = fl1;
            end
            4: begin
                o_busy = busy4; o_done = done4; o_c = c4;
                o_y = {32'b0, y4}; o_fl = fl4;
            end
            default: ;
        endcase
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(int nb, logic v);
        case (nb)
            1:       start1 = v;
            4:       start4 = v;
            default: start2 = v;
        endcase
    endtask

    function automatic res_t model(int nb, logic [2:0] fn,
                                   logic [63:0] av, logic [63:0] bv,
                                   logic ci);
        res_t        r;
        logic [64:0] m, s, aa, bb;
        int          w;
        w  = 8 * nb;
        m  = (65'd1 << w) - 65'd1;
        aa = {1'b0, av} & m;
        bb = {1'b0, bv} & m;
        s  = '0;
        r.c = 1'b0;
        case (fn)
            OUTPUT_A_PLUS_B: begin
                s   = aa + bb + 65'(ci);
                r.c = s[w];
            end
            OUTPUT_A_MINUS_B: begin
                s   = aa - bb - 65'(ci);
                r.c = (aa < bb + 65'(ci));
            end
            OUTPUT_A_AND_B: s = aa & bb;
            OUTPUT_A_OR_B:  s = aa | bb;
            OUTPUT_A_XOR_B: s = aa ^ bb;
            OUTPUT_NOT_A:   s = ~aa;
            OUTPUT_A:       s = aa;
            default:        s = bb;
        endcase
        s   = s & m;
        r.y = s[63:0];
        if (fn == OUTPUT_A_PLUS_B && r.c)       r.fl = OVERFLOW_FLAG;
        else if (fn == OUTPUT_A_MINUS_B && r.c) r.fl = NEGATIVE_FLAG;
        else if (r.y == 64'd0)                  r.fl = ZERO_FLAG;
        else                                    r.fl = DEFAULT_FLAG;
        return r;
    endfunction

    task automatic run_op(int nb, logic [2:0] fn, logic [63:0] av,
                          logic [63:0] bv, logic ci, logic [63:0] ey,
                          logic ec, logic [1:0] ef, bit scr);
        res_t e;
        bit   seen;
        sel = nb;
        @(negedge clk);
        a = av; b = bv; f = fn; cin = ci;
        set_start(nb, 1'b1);
        e = '{ey, ec, ef};
        sb.push_back(e);
        seen = 0;
        for (int c = 1; c <= nb + 4 && !seen; c++) begin
            @(negedge clk);
            set_start(nb, 1'b0);
            if (scr && c == 1) begin
                a = ~av; b = {$urandom, $urandom};
                f = fn ^ 3'd5; cin = ~ci;
            end
            if (o_done) begin
                seen = 1;
                e = sb.pop_front();
                chk("latency", 64'(c), 64'(nb + 1));
                chk("busy_at_done", 64'(o_busy), 64'd1);
                chk("y", o_y, e.y);
                chk("carry", 64'(o_c), 64'(e.c));
                chk("flag", 64'(o_fl), 64'(e.fl));
            end
        end
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done), 64'd0);
        chk("idle_after", 64'(o_busy), 64'd0);
        chk("y_hold", o_y, ey);
    endtask

    initial begin
        res_t r;
        int   pulses, last, nb;
        logic [2:0]  rf;
        logic [63:0] ra, rb;
        logic        rc;

        repeat (2) @(negedge clk);
        sel = 2;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_y", o_y, 64'd0);
        chk("rst_carry", 64'(o_c), 64'd0);
        chk("rst_flag", 64'(o_fl), 64'(DEFAULT_FLAG));
        rst = 1'b0;

        run_op(2, OUTPUT_A_PLUS_B, 64'h00FF, 64'h0001, 0,
               64'h0100, 0, DEFAULT_FLAG, 0);
        run_op(2, OUTPUT_A_PLUS_B, 64'hFFFF, 64'h0001, 0,
               64'h0000, 1, OVERFLOW_FLAG, 0);
        run_op(2, OUTPUT_A_PLUS_B, 64'h0001, 64'h0001, 1,
               64'h0003, 0, DEFAULT_FLAG, 0);
        run_op(2, OUTPUT_A_MINUS_B, 64'h0100, 64'h0001, 0,
               64'h00FF, 0, DEFAULT_FLAG, 0);
        run_op(2, OUTPUT_A_MINUS_B, 64'h0000, 64'h0001, 0,
               64'hFFFF, 1, NEGATIVE_FLAG, 0);
        run_op(2, OUTPUT_A_MINUS_B, 64'h1234, 64'h1234, 0,
               64'h0000, 0, ZERO_FLAG, 0);
        run_op(2, OUTPUT_A_MINUS_B, 64'h0005, 64'h0002, 1,
               64'h0002, 0, DEFAULT_FLAG, 0);
        run_op(2, OUTPUT_A_AND_B, 64'hF0F0, 64'h0F0F, 1,
               64'h0000, 0, ZERO_FLAG, 0);
        run_op(2, OUTPUT_A_XOR_B, 64'h1234, 64'hFFFF, 1,
               64'hEDCB, 0, DEFAULT_FLAG, 0);
        run_op(2, OUTPUT_A_PLUS_B, 64'h1111, 64'h2222, 0,
               64'h3333, 0, DEFAULT_FLAG, 1);

        run_op(1, OUTPUT_A_PLUS_B, 64'hFF, 64'h01, 0,
               64'h00, 1, OVERFLOW_FLAG, 0);
        run_op(1, OUTPUT_A_MINUS_B, 64'h00, 64'h01, 0,
               64'hFF, 1, NEGATIVE_FLAG, 0);
        run_op(1, OUTPUT_A_PLUS_B, 64'h7F, 64'h01, 0,
               64'h80, 0, DEFAULT_FLAG, 0);
        run_op(4, OUTPUT_A_PLUS_B, 64'hFFFF_FFFF, 64'h1, 0,
               64'h0, 1, OVERFLOW_FLAG, 0);
        run_op(4, OUTPUT_A_MINUS_B, 64'h0, 64'h1, 0,
               64'hFFFF_FFFF, 1, NEGATIVE_FLAG, 0);
        run_op(4, OUTPUT_A_PLUS_B, 64'h00FF_FFFF, 64'h1, 0,
               64'h0100_0000, 0, DEFAULT_FLAG, 0);

        // start held high: one done every NUM_BYTES+2 cycles
        sel = 2;
        @(negedge clk);
        a = 64'h0102; b = 64'h0304; f = OUTPUT_A_PLUS_B; cin = 0;
        start2 = 1'b1;
        repeat (4) begin
            r = '{64'h0406, 1'b0, DEFAULT_FLAG};
            sb.push_back(r);
        end
        pulses = 0;
        last = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (o_done) begin
                pulses++;
                if (pulses == 1) chk("hold_first", 64'(i), 64'd3);
                else             chk("hold_gap", 64'(i - last), 64'd4);
                last = i;
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    chk("hold_y", o_y, r.y);
                end
            end
        end
        start2 = 1'b0;
        chk("hold_pulses", 64'(pulses), 64'd4);
        sb.delete();
        repeat (6) @(negedge clk);

        // reset in the first RUN cycle
        @(negedge clk);
        a = 64'h00AA; b = 64'h0011; f = OUTPUT_A_PLUS_B; cin = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("pre_rst_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_y", o_y, 64'd0);
        chk("mid_rst_done", 64'(o_done), 64'd0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_done) pulses++;
        end
        chk("no_done_after_abort", 64'(pulses), 64'd0);
        run_op(2, OUTPUT_A_PLUS_B, 64'h00AA, 64'h0011, 0,
               64'h00BB, 0, DEFAULT_FLAG, 0);

        for (int k = 0; k < 3; k++) begin
            nb = (k == 0) ? 1 : (k == 1) ? 4 : 2;
            repeat ((k == 2) ? 200 : 1000) begin
                rf = 3'($urandom_range(0, 7));
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) rb = ra;
                rc = 1'($urandom_range(0, 1));
                r  = model(nb, rf, ra, rb, rc);
                run_op(nb, rf, ra, rb, rc, r.y, r.c, r.fl, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
